// File: rtl/tdm_demux.sv
// Time-division demultiplexer: one framed sample stream in,
// one registered slice per channel out, with framing supervision.
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      frame_done,
    output logic                      sync_err,
    output logic                      locked
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam logic [CH_W-1:0] LAST = CH_W'(CHANNELS - 1);
    localparam logic [CH_W-1:0] ONE  = CH_W'(1);

    state_t          state;
    logic [CH_W-1:0] cnt;

    logic hunt_drop;
    logic hunt_sync;
    logic lock_sync;
    logic lock_miss;

    always_comb begin
        hunt_drop = (state == HUNT) && !in_sync;
        hunt_sync = (state == HUNT) && in_sync;
        lock_sync = (state == LOCKED) && in_sync;
        lock_miss = (state == LOCKED) && !in_sync && (cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            cnt        <= '0;
            out_data   <= '0;
            out_valid  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            out_valid  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (in_valid) begin
                unique case (1'b1)
                    hunt_drop: begin
                    end
                    hunt_sync: begin
                        out_data[WIDTH-1:0] <= in_data;
                        out_valid[0]        <= 1'b1;
                        cnt                 <= ONE;
                        state               <= LOCKED;
                    end
                    lock_sync: begin
                        // an early sync realigns the frame onto slot 0
                        out_data[WIDTH-1:0] <= in_data;
                        out_valid[0]        <= 1'b1;
                        cnt                 <= ONE;
                        sync_err            <= (cnt != '0);
                    end
                    lock_miss: begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                    end
                    default: begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (cnt == CH_W'(k)) begin
                                out_data[k*WIDTH +: WIDTH] <= in_data;
                                out_valid[k]               <= 1'b1;
                            end
                        end
                        frame_done <= (cnt == LAST);
                        cnt        <= (cnt == LAST) ? '0 : cnt + ONE;
                    end
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Table-driven bench for tdm_demux with a queued expectation
// per applied sample, checked one cycle later.
module tb_tdm_demux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_sync;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic                      frame_done;
    logic                      sync_err;
    logic                      locked;

    tdm_demux #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .CH_W    (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_done(frame_done),
        .sync_err  (sync_err),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [3:0]  ov;
        logic        fd;
        logic        err;
        logic        lk;
        logic [31:0] od;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   n_step;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        cmp({tag, " out_valid"}, 32'(out_valid), 32'(e.ov));
        cmp({tag, " frame_done"}, 32'(frame_done), 32'(e.fd));
        cmp({tag, " sync_err"}, 32'(sync_err), 32'(e.err));
        cmp({tag, " locked"}, 32'(locked), 32'(e.lk));
        cmp({tag, " out_data"}, out_data, e.od);
        cmp({tag, " onehot"}, 32'($onehot0(out_valid)), 32'd1);
    endtask

    task automatic apply(input vec_t r);
        vec_t e;
        in_valid = r.v;
        in_sync  = r.s;
        in_data  = r.d;
        sb.push_back(r);
        @(posedge clk);
        #1;
        n_step++;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: empty queue at step %0d", n_step);
        end else begin
            e = sb.pop_front();
            check_outputs($sformatf("step%0d", n_step), e);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic s,
                                input logic [7:0] d, input logic [3:0] ov,
                                input logic fd, input logic err,
                                input logic lk, input logic [31:0] od);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ov = ov;
        r.fd = fd; r.err = err; r.lk = lk; r.od = od;
        return r;
    endfunction

    initial begin
        vec_t z;
        n_cmp    = 0;
        n_bad    = 0;
        n_step   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;

        // basic frame
        vecs.push_back(mk(1, 1, 8'h11, 4'b0001, 0, 0, 1, 32'h00000011));
        vecs.push_back(mk(1, 0, 8'h22, 4'b0010, 0, 0, 1, 32'h00002211));
        vecs.push_back(mk(1, 0, 8'h33, 4'b0100, 0, 0, 1, 32'h00332211));
        vecs.push_back(mk(1, 0, 8'h44, 4'b1000, 1, 0, 1, 32'h44332211));
        // missing sync at frame boundary
        vecs.push_back(mk(1, 0, 8'h55, 4'b0000, 0, 1, 0, 32'h44332211));
        // hunting: unsynced samples discarded, then relock
        vecs.push_back(mk(1, 0, 8'hAA, 4'b0000, 0, 0, 0, 32'h44332211));
        vecs.push_back(mk(1, 0, 8'hBB, 4'b0000, 0, 0, 0, 32'h44332211));
        vecs.push_back(mk(1, 1, 8'h01, 4'b0001, 0, 0, 1, 32'h44332201));
        vecs.push_back(mk(1, 0, 8'h02, 4'b0010, 0, 0, 1, 32'h44330201));
        vecs.push_back(mk(1, 0, 8'h03, 4'b0100, 0, 0, 1, 32'h44030201));
        vecs.push_back(mk(1, 0, 8'h04, 4'b1000, 1, 0, 1, 32'h04030201));
        // idle gaps mid-frame; sync without valid is ignored
        vecs.push_back(mk(1, 1, 8'h05, 4'b0001, 0, 0, 1, 32'h04030205));
        vecs.push_back(mk(1, 0, 8'h06, 4'b0010, 0, 0, 1, 32'h04030605));
        vecs.push_back(mk(0, 0, 8'hEE, 4'b0000, 0, 0, 1, 32'h04030605));
        vecs.push_back(mk(0, 1, 8'h77, 4'b0000, 0, 0, 1, 32'h04030605));
        vecs.push_back(mk(0, 0, 8'hEF, 4'b0000, 0, 0, 1, 32'h04030605));
        vecs.push_back(mk(1, 0, 8'h07, 4'b0100, 0, 0, 1, 32'h04070605));
        vecs.push_back(mk(1, 0, 8'h08, 4'b1000, 1, 0, 1, 32'h08070605));
        // early sync at slot 2
        vecs.push_back(mk(1, 1, 8'h10, 4'b0001, 0, 0, 1, 32'h08070610));
        vecs.push_back(mk(1, 0, 8'h20, 4'b0010, 0, 0, 1, 32'h08072010));
        vecs.push_back(mk(1, 1, 8'h30, 4'b0001, 0, 1, 1, 32'h08072030));
        vecs.push_back(mk(1, 0, 8'h40, 4'b0010, 0, 0, 1, 32'h08074030));
        vecs.push_back(mk(1, 0, 8'h50, 4'b0100, 0, 0, 1, 32'h08504030));
        vecs.push_back(mk(1, 0, 8'h60, 4'b1000, 1, 0, 1, 32'h60504030));
        // partial frame before an async reset
        vecs.push_back(mk(1, 1, 8'hA1, 4'b0001, 0, 0, 1, 32'h605040A1));
        vecs.push_back(mk(1, 0, 8'hA2, 4'b0010, 0, 0, 1, 32'h6050A2A1));

        z = mk(0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h0);

        #1;
        check_outputs("reset", z);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // async reset mid-frame, between clock edges
        in_valid = 1'b1;
        in_sync  = 1'b0;
        in_data  = 8'hA3;
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", z);
        @(posedge clk);
        #1;
        check_outputs("held_rst", z);
        rst = 1'b0;

        apply(mk(1, 0, 8'hB2, 4'b0000, 0, 0, 0, 32'h00000000));
        apply(mk(1, 0, 8'hB3, 4'b0000, 0, 0, 0, 32'h00000000));
        apply(mk(1, 1, 8'hC0, 4'b0001, 0, 0, 1, 32'h000000C0));
        apply(mk(1, 0, 8'hC1, 4'b0010, 0, 0, 1, 32'h0000C1C0));
        apply(mk(0, 0, 8'h00, 4'b0000, 0, 0, 1, 32'h0000C1C0));

        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
